// File: rtl/ball_pkg.sv
// rtl/ball_pkg.sv - shared ball/screen constants and pixel colour type
package ball_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam int H_VISIBLE         = 640;
    localparam int V_VISIBLE         = 480;

    localparam int BALL_X_CENTER     = 320;
    localparam int BALL_Y_CENTER     = 240;
    localparam int BALL_SIZE_DEFAULT = 4;

    localparam int RENDER_LAT        = 3;

    function automatic rgb_t to_rgb(input logic [23:0] c);
        return rgb_t'(c);
    endfunction

endpackage

// File: rtl/sync_delay.sv
// rtl/sync_delay.sv - fixed-depth shift register with a reset pattern
module sync_delay #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] taps [DEPTH];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                taps[i] <= RESET_VAL;
            end
        end else begin
            taps[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

    assign q = taps[DEPTH-1];

endmodule

// File: rtl/ball_renderer.sv
// rtl/ball_renderer.sv - frame-latched ball shadow and 3-stage circle test driving RGB
module ball_renderer
    import ball_pkg::*;
#(
    parameter logic [23:0] BALL_RGB = 24'hFF5500,
    parameter logic [23:0] BG_RGB   = 24'h3F007F,
    parameter logic [9:0]  X_RESET  = 10'(BALL_X_CENTER),
    parameter logic [9:0]  Y_RESET  = 10'(BALL_Y_CENTER),
    parameter logic [9:0]  S_RESET  = 10'(BALL_SIZE_DEFAULT)
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       de_in,
    input  logic       hs_in,
    input  logic       vs_in,
    input  logic       frame_start,
    input  logic [9:0] BallX,
    input  logic [9:0] BallY,
    input  logic [9:0] BallS,
    output logic [7:0] Red,
    output logic [7:0] Green,
    output logic [7:0] Blue,
    output logic       hs_out,
    output logic       vs_out,
    output logic       de_out,
    output logic       ball_hit
);

    localparam rgb_t BALL_COLOUR = to_rgb(BALL_RGB);
    localparam rgb_t BG_COLOUR   = to_rgb(BG_RGB);

    logic [9:0] shadow_x;
    logic [9:0] shadow_y;
    logic [9:0] shadow_s;

    // Ball state only moves at frame boundaries so a frame never tears.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            shadow_x <= X_RESET;
            shadow_y <= Y_RESET;
            shadow_s <= S_RESET;
        end else if (frame_start) begin
            shadow_x <= BallX;
            shadow_y <= BallY;
            shadow_s <= BallS;
        end
    end

    logic signed [10:0] dx_s1;
    logic signed [10:0] dy_s1;
    logic        [19:0] s2_s1;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            dx_s1 <= '0;
            dy_s1 <= '0;
            s2_s1 <= '0;
        end else begin
            dx_s1 <= $signed({1'b0, DrawX} - {1'b0, shadow_x});
            dy_s1 <= $signed({1'b0, DrawY} - {1'b0, shadow_y});
            s2_s1 <= 20'(shadow_s) * 20'(shadow_s);
        end
    end

    logic [20:0] dx2_s2;
    logic [20:0] dy2_s2;
    logic [19:0] s2_s2;

    // Squares of an 11-bit signed value fit in 21 bits, so no sign survives.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            dx2_s2 <= '0;
            dy2_s2 <= '0;
            s2_s2  <= '0;
        end else begin
            dx2_s2 <= $unsigned(21'(dx_s1) * 21'(dx_s1));
            dy2_s2 <= $unsigned(21'(dy_s1) * 21'(dy_s1));
            s2_s2  <= s2_s1;
        end
    end

    // {de, hs, vs} aligned with the stage-2 data; the output stage adds the last delay.
    logic [2:0] ctl_s2;

    sync_delay #(
        .WIDTH     (3),
        .DEPTH     (RENDER_LAT - 1),
        .RESET_VAL (3'b011)
    ) u_ctl_delay (
        .Clk   (Clk),
        .Reset (Reset),
        .d     ({de_in, hs_in, vs_in}),
        .q     (ctl_s2)
    );

    logic        de_s2;
    logic [21:0] dist2;
    logic        hit;
    rgb_t        pixel;

    always_comb begin
        de_s2 = ctl_s2[2];
        dist2 = 22'(dx2_s2) + 22'(dy2_s2);
        hit   = de_s2 && (dist2 <= {2'b0, s2_s2});
        if (hit) begin
            pixel = BALL_COLOUR;
        end else if (de_s2) begin
            pixel = BG_COLOUR;
        end else begin
            pixel = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            Red      <= '0;
            Green    <= '0;
            Blue     <= '0;
            ball_hit <= 1'b0;
            de_out   <= 1'b0;
            hs_out   <= 1'b1;
            vs_out   <= 1'b1;
        end else begin
            Red      <= pixel.r;
            Green    <= pixel.g;
            Blue     <= pixel.b;
            ball_hit <= hit;
            de_out   <= de_s2;
            hs_out   <= ctl_s2[1];
            vs_out   <= ctl_s2[0];
        end
    end

endmodule
